// File: rtl/pc_seq_pkg.sv
// ============================================================================
// pc_seq_pkg : shared state encoding and default sizes for the PC sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_seq_state_t;

  localparam int PC_SEQ_AW_DEF        = 5;
  localparam int PC_SEQ_RAS_DEPTH_DEF = 4;

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
// pc_ras : circular return-address stack with push, pop and top-replace
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_ras
  import pc_seq_pkg::*;
#(
  parameter int AW        = PC_SEQ_AW_DEF,
  parameter int RAS_DEPTH = PC_SEQ_RAS_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          replace_i,
  input  logic [AW-1:0] data_i,
  output logic [AW-1:0] top_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = $clog2(RAS_DEPTH);

  logic [AW-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0] sp_q, sp_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [PW-1:0] top_idx;

  // sp_q points at the next free slot; the newest entry sits just below it.
  assign top_idx = sp_q - 1'b1;
  assign top_o   = mem_q[top_idx];
  assign full_o  = (cnt_q == (PW+1)'(RAS_DEPTH));
  assign empty_o = (cnt_q == '0);

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (replace_i) begin
      sp_d  = sp_q;
    end else if (pop_i && !empty_o) begin
      sp_d  = sp_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end else if (push_i) begin
      sp_d  = sp_q + 1'b1;
      cnt_d = full_o ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is left unreset; the count alone decides what is readable.
  always_ff @(posedge clk) begin
    if (replace_i) begin
      mem_q[top_idx] <= data_i;
    end else if (push_i && !pop_i) begin
      mem_q[sp_q] <= data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : registered PC with step/branch/jump redirects and fetch
// handshake; optional return-address stack built when PC_SEQ_RAS_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int AW        = PC_SEQ_AW_DEF,
  parameter int STEP      = 1,
  parameter int RESET_PC  = 0,
  parameter int RAS_DEPTH = PC_SEQ_RAS_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          halt,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [AW-1:0] br_offset,
  input  logic          jmp_en,
  input  logic [AW-1:0] jmp_target,
  input  logic          call,
  input  logic          ret,
  input  logic          pc_ready,
  output logic [AW-1:0] pc,
  output logic          pc_valid,
  output logic          ras_ovf,
  output logic          ras_unf
);

  localparam logic [AW-1:0] STEP_W     = AW'(STEP);
  localparam logic [AW-1:0] RESET_PC_W = AW'(RESET_PC);

  pc_seq_state_t state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] pc_inc;

  assign pc_inc = pc_q + STEP_W;

`ifdef PC_SEQ_RAS_EN
  logic          push, pop, replace;
  logic [AW-1:0] ras_top;
  logic          ras_full, ras_empty;
  logic          ovf_q, ovf_d, unf_q, unf_d;

  pc_ras #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .pop_i     (pop),
    .replace_i (replace),
    .data_i    (pc_inc),
    .top_o     (ras_top),
    .full_o    (ras_full),
    .empty_o   (ras_empty)
  );
`else
  localparam int RAS_DEPTH_UNUSED = RAS_DEPTH;
  logic ret_unused;
  assign ret_unused = ret;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_SEQ_RAS_EN
    push    = 1'b0;
    pop     = 1'b0;
    replace = 1'b0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        pc_d = RESET_PC_W;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (halt) state_d = HALT;
`ifdef PC_SEQ_RAS_EN
        // A return with nothing stacked falls through to the lower rules.
        unf_d = ret && ras_empty;
        if (call && ret && !ras_empty) begin
          pc_d    = ras_top;
          replace = 1'b1;
        end else if (ret && !ras_empty) begin
          pc_d = ras_top;
          pop  = 1'b1;
        end else if (call) begin
          pc_d  = jmp_target;
          push  = 1'b1;
          ovf_d = ras_full;
        end else if (jmp_en) begin
          pc_d = jmp_target;
        end else if (br_taken) begin
          pc_d = pc_q + br_offset;
        end else if (pc_ready && !stall) begin
          pc_d = pc_inc;
        end
`else
        if (call || jmp_en) begin
          pc_d = jmp_target;
        end else if (br_taken) begin
          pc_d = pc_q + br_offset;
        end else if (pc_ready && !stall) begin
          pc_d = pc_inc;
        end
`endif
      end
      HALT: begin
        if (start) state_d = RUN;
      end
      default: begin
        state_d = IDLE;
        pc_d    = RESET_PC_W;
      end
    endcase
    valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC_W;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

`ifdef PC_SEQ_RAS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;
`else
  assign ras_ovf = 1'b0;
  assign ras_unf = 1'b0;
`endif

  assign pc       = pc_q;
  assign pc_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer : directed self-checking bench for pc_sequencer (AW=5)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, halt, stall, br_taken, jmp_en, call, ret, pc_ready;
  logic [4:0] br_offset, jmp_target;
  logic [4:0] pc;
  logic       pc_valid, ras_ovf, ras_unf;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .AW        (5),
    .STEP      (1),
    .RESET_PC  (0),
    .RAS_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .halt       (halt),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_offset  (br_offset),
    .jmp_en     (jmp_en),
    .jmp_target (jmp_target),
    .call       (call),
    .ret        (ret),
    .pc_ready   (pc_ready),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .ras_ovf    (ras_ovf),
    .ras_unf    (ras_unf)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; halt = 0; stall = 0; br_taken = 0; jmp_en = 0;
    call = 0; ret = 0; pc_ready = 0; br_offset = '0; jmp_target = '0;
  endtask

  task automatic jump_to(input logic [4:0] t);
    jmp_en = 1; jmp_target = t;
    step();
    jmp_en = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    #3;
    check_eq("rst_pc", pc, 0);
    check_eq("rst_valid", pc_valid, 0);
    check_eq("rst_ovf", ras_ovf, 0);
    check_eq("rst_unf", ras_unf, 0);
    step(); step();
    rst_n = 1;
    pc_ready = 1;
    step();
    check_eq("idle_pc", pc, 0);
    check_eq("idle_valid", pc_valid, 0);

    start = 1;
    step();
    start = 0;
    check_eq("start_valid", pc_valid, 1);
    check_eq("start_pc", pc, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_eq("seq_pc", pc, i);
    end

    jump_to(5'd30);
    check_eq("jmp30", pc, 30);
    step(); check_eq("wrap31", pc, 31);
    step(); check_eq("wrap0", pc, 0);

    jump_to(5'd10);
    stall = 1; br_taken = 1; br_offset = 5'b11101;
    step();
    br_taken = 0;
    check_eq("br_stall", pc, 7);
    jump_to(5'd10);
    check_eq("jmp_over_stall", pc, 10);
    step(); check_eq("stall_hold1", pc, 10);
    step(); check_eq("stall_hold2", pc, 10);
    stall = 0;

    jump_to(5'd4);
    jmp_en = 1; jmp_target = 5'd20; br_taken = 1; br_offset = 5'd5;
    step();
    jmp_en = 0; br_taken = 0;
    check_eq("jmp_over_br", pc, 20);

    halt = 1; jmp_en = 1; jmp_target = 5'd12;
    step();
    halt = 0;
    check_eq("halt_redir_pc", pc, 12);
    check_eq("halt_valid", pc_valid, 0);
    jmp_target = 5'd25;
    step();
    jmp_en = 0;
    check_eq("halt_frozen", pc, 12);
    start = 1;
    step();
    start = 0;
    check_eq("resume_valid", pc_valid, 1);
    check_eq("resume_pc", pc, 12);
    step(); check_eq("resume_inc", pc, 13);

`ifdef PC_SEQ_RAS_EN
    jump_to(5'd3);
    call = 1; jmp_target = 5'd16;
    step(); call = 0;
    check_eq("call_pc", pc, 16);
    step(); check_eq("after_call", pc, 17);
    ret = 1; step(); ret = 0;
    check_eq("ret_pc", pc, 4);
    check_eq("ret_unf0", ras_unf, 0);
    ret = 1; step(); ret = 0;
    check_eq("unf_pc", pc, 5);
    check_eq("unf_pulse", ras_unf, 1);
    step();
    check_eq("unf_clear", ras_unf, 0);
    check_eq("unf_next_pc", pc, 6);
    for (int i = 0; i < 5; i++) begin
      call = 1; jmp_target = 5'(10 + 2 * i);
      step();
      check_eq("calls_pc", pc, 10 + 2 * i);
      check_eq("calls_ovf", ras_ovf, (i == 4) ? 1 : 0);
    end
    call = 0;
    ret = 1;
    step(); check_eq("pop_17", pc, 17); check_eq("ovf_clear", ras_ovf, 0);
    step(); check_eq("pop_15", pc, 15);
    step(); check_eq("pop_13", pc, 13);
    step(); check_eq("pop_11", pc, 11); check_eq("pop_unf0", ras_unf, 0);
    step(); check_eq("empty_seq", pc, 12); check_eq("empty_unf", ras_unf, 1);
    ret = 0;
    call = 1; jmp_target = 5'd5;
    step(); check_eq("call5", pc, 5);
    ret = 1; jmp_target = 5'd25;
    step(); call = 0;
    check_eq("callret_pc", pc, 13);
    step(); check_eq("replaced_top", pc, 6);
    step(); ret = 0;
    check_eq("replace_depth", pc, 7);
    check_eq("replace_unf", ras_unf, 1);
`else
    call = 1; jmp_target = 5'd16;
    step(); call = 0;
    check_eq("call_as_jmp", pc, 16);
    check_eq("noras_ovf", ras_ovf, 0);
    ret = 1;
    step(); check_eq("ret_ignored", pc, 17);
    check_eq("noras_unf", ras_unf, 0);
    pc_ready = 0;
    step(); check_eq("ret_hold", pc, 17);
    ret = 0; pc_ready = 1;
`endif

    jump_to(5'd9);
    check_eq("pre_rst_pc", pc, 9);
    #2 rst_n = 0;
    #1;
    check_eq("async_rst_pc", pc, 0);
    check_eq("async_rst_valid", pc_valid, 0);
    #1 rst_n = 1;
    step();
    check_eq("post_rst_idle_pc", pc, 0);
    check_eq("post_rst_idle_valid", pc_valid, 0);
    start = 1;
    step(); start = 0;
    check_eq("post_rst_start", pc_valid, 1);
    step(); check_eq("post_rst_inc", pc, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
